// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative unsigned integer square root, one root bit per cycle.
// Ports:
//   aclk, areset             clock and async active-high reset
//   s_axis_cartesian_*       radicand stream (tvalid/tready/tdata)
//   m_axis_dout_*            root stream, root in low WIDTH/2 bits
module sqrt_iter #(
    parameter int WIDTH = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             s_axis_cartesian_tvalid,
    output logic             s_axis_cartesian_tready,
    input  logic [WIDTH-1:0] s_axis_cartesian_tdata,
    output logic             m_axis_dout_tvalid,
    input  logic             m_axis_dout_tready,
    output logic [WIDTH-1:0] m_axis_dout_tdata
);

    localparam int HW = WIDTH / 2;
    localparam int PW = HW + 2;
    localparam int TW = HW + 4;
    localparam int CW = $clog2(HW);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] x;
    logic [HW-1:0]   r;
    logic [PW-1:0]   p;
    logic [CW-1:0]   cnt;

    logic [TW-1:0]   p_shift;
    logic [TW-1:0]   trial;
    logic [PW-1:0]   p_next;
    logic [HW-1:0]   r_next;

    // The trial subtraction carries a spare sign bit; a set top bit means
    // the candidate root bit is 0 and the shifted remainder is kept.
    always_comb begin
        p_shift = {p, x[WIDTH-1 -: 2]};
        trial   = p_shift - {2'b00, r, 2'b01};
        p_next  = p_shift[PW-1:0];
        r_next  = {r[HW-2:0], 1'b0};
        if (!trial[TW-1]) begin
            p_next = trial[PW-1:0];
            r_next = {r[HW-2:0], 1'b1};
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state                   <= IDLE;
            x                       <= '0;
            r                       <= '0;
            p                       <= '0;
            cnt                     <= '0;
            s_axis_cartesian_tready <= 1'b1;
            m_axis_dout_tvalid      <= 1'b0;
            m_axis_dout_tdata       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_axis_cartesian_tvalid && s_axis_cartesian_tready) begin
                        x                       <= s_axis_cartesian_tdata;
                        r                       <= '0;
                        p                       <= '0;
                        cnt                     <= CW'(HW - 1);
                        s_axis_cartesian_tready <= 1'b0;
                        state                   <= CALC;
                    end
                end
                CALC: begin
                    x   <= {x[WIDTH-3:0], 2'b00};
                    r   <= r_next;
                    p   <= p_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        m_axis_dout_tvalid <= 1'b1;
                        m_axis_dout_tdata  <= {{(WIDTH-HW){1'b0}}, r_next};
                        state              <= DONE;
                    end
                end
                DONE: begin
                    if (m_axis_dout_tready) begin
                        m_axis_dout_tvalid      <= 1'b0;
                        s_axis_cartesian_tready <= 1'b1;
                        state                   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: directed and random checks for the sqrt_iter engine.
// Drives/samples 1 time unit after each rising edge.
module tb_sqrt_iter;

    logic        aclk;
    logic        areset;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [15:0] m_tdata;

    int checks = 0;
    int errors = 0;

    sqrt_iter #(.WIDTH(16)) dut (
        .aclk                    (aclk),
        .areset                  (areset),
        .s_axis_cartesian_tvalid (s_tvalid),
        .s_axis_cartesian_tready (s_tready),
        .s_axis_cartesian_tdata  (s_tdata),
        .m_axis_dout_tvalid      (m_tvalid),
        .m_axis_dout_tready      (m_tready),
        .m_axis_dout_tdata       (m_tdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic int isqrt(input int v);
        int k;
        k = 0;
        while ((k + 1) * (k + 1) <= v) k++;
        return k;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Push one radicand, wait for the result, then release it after
    // rdy_gap cycles of backpressure. got stays X if anything times out.
    task automatic xfer(input logic [15:0] xin, input int rdy_gap,
                        output logic [15:0] got, output int lat);
        got = 'x;
        lat = -1;
        s_tvalid = 1'b1;
        s_tdata = xin;
        for (int i = 0; i < 50; i++) begin
            if (s_tready) break;
            tick();
        end
        if (s_tready) begin
            tick();
            s_tvalid = 1'b0;
            s_tdata = 16'($urandom);
            for (int i = 1; i <= 50; i++) begin
                tick();
                if (m_tvalid) begin
                    lat = i;
                    break;
                end
            end
            if (lat > 0) begin
                got = m_tdata;
                if (rdy_gap > 0) begin
                    m_tready = 1'b0;
                    repeat (rdy_gap) tick();
                    m_tready = 1'b1;
                end
                tick();
            end
        end else begin
            s_tvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        m_tready = 1'b0;
        repeat (2) tick();
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_tready got %b want 1", s_tready);
        end
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_m_tvalid got %b want 0", m_tvalid);
        end
        checks++;
        if (m_tdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_m_tdata got %0d want 0", m_tdata);
        end
        areset = 1'b0;
        m_tready = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] got;
        int lat;
        xfer(16'd1024, 0, got, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        checks++;
        if (got !== 16'd32) begin
            errors++;
            $display("FAIL basic_root got %0d want 32", got);
        end
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return_idle got tready=%b tvalid=%b want 1 0",
                     s_tready, m_tvalid);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] xs [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4,
                                16'd65535, 16'd65025, 16'd65024};
        logic [15:0] rs [8] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2,
                                16'd255, 16'd255, 16'd254};
        logic [15:0] got;
        int lat;
        for (int i = 0; i < 8; i++) begin
            xfer(xs[i], 0, got, lat);
            checks++;
            if (got !== rs[i]) begin
                errors++;
                $display("FAIL boundary x=%0d got %0d want %0d", xs[i], got, rs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int seen;
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = 16'd1000;
        tick();
        s_tvalid = 1'b0;
        s_tdata = 16'd9;
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (m_tvalid) begin
                seen = i;
                break;
            end
        end
        checks++;
        if (seen !== 8) begin
            errors++;
            $display("FAIL bp_latency got %0d want 8", seen);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 16'd31 || s_tready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%0d rdy=%b want 1 31 0",
                         i, m_tvalid, m_tdata, s_tready);
            end
            tick();
        end
        m_tready = 1'b1;
        tick();
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b want 0 1", m_tvalid, s_tready);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        s_tvalid = 1'b1;
        s_tdata = 16'd10000;
        tick();
        s_tdata = 16'd400;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (m_tvalid) begin
                lat = i;
                break;
            end
            checks++;
            if (s_tready !== 1'b0) begin
                errors++;
                $display("FAIL busy_tready cyc=%0d got %b want 0", i, s_tready);
            end
        end
        checks++;
        if (lat !== 8 || m_tdata !== 16'd100) begin
            errors++;
            $display("FAIL busy_first got lat=%0d d=%0d want 8 100", lat, m_tdata);
        end
        tick();
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle got rdy=%b v=%b want 1 0", s_tready, m_tvalid);
        end
        tick();
        s_tvalid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (m_tvalid) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 8 || m_tdata !== 16'd20) begin
            errors++;
            $display("FAIL busy_second got lat=%0d d=%0d want 8 20", lat, m_tdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        int lat;
        int leak;
        s_tvalid = 1'b1;
        s_tdata = 16'd50000;
        tick();
        s_tvalid = 1'b0;
        repeat (4) tick();
        areset = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || m_tdata !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid got rdy=%b v=%b d=%0d want 1 0 0",
                     s_tready, m_tvalid, m_tdata);
        end
        tick();
        tick();
        areset = 1'b0;
        leak = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_tvalid) leak++;
        end
        checks++;
        if (leak !== 0) begin
            errors++;
            $display("FAIL rst_mid_leak got %0d valid cycles want 0", leak);
        end
        xfer(16'd50000, 0, got, lat);
        checks++;
        if (got !== 16'd223) begin
            errors++;
            $display("FAIL rst_mid_after got %0d want 223", got);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] xin;
        logic [15:0] got;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            xin = 16'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            xfer(xin, int'($urandom_range(0, 3)), got, lat);
            checks++;
            if (got !== 16'(isqrt(int'(xin)))) begin
                errors++;
                $display("FAIL sweep n=%0d x=%0d got %0d want %0d",
                         n, xin, got, isqrt(int'(xin)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
